acc_buffer_ring: RTL and testbench

- N-bank rotating accumulation buffer; generalises the two-bank ping-pong accumulator to NBANK banks.
- Adds valid/ready handshakes on both sides, explicit end-of-window marking, per-bank saturation flags and back-pressure when all banks are full.
- Sits between unary/bitstream compute lanes and downstream binary consumers. Lanes accumulate counts into one bank while previously completed windows drain.

---
 rtl/acc_buffer_ring_pkg.sv | 16 +
 rtl/acc_buffer_ring_if.sv | 34 +++
 rtl/acc_buffer_ring_bank.sv | 77 +++++++
 rtl/acc_buffer_ring.sv | 96 +++++++++
 tb/tb_acc_buffer_ring.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/acc_buffer_ring_pkg.sv
// Package for the rotating accumulation buffer.
//   bank_state_t : per-bank life cycle EMPTY -> ACC -> FULL -> EMPTY
//   ptr_inc      : ring-pointer increment with wrap from nbank-1 to 0
package acc_buffer_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ACC   = 2'd1,
        FULL  = 2'd2
    } bank_state_t;

    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned nbank);
        return (ptr >= nbank - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/acc_buffer_ring_if.sv
// Handshake bundle for acc_buffer_ring.
//   Input side : iValid, oInReady, iLast, iClear, iData[IDIM]
//   Output side: oValid, iOutReady, oData[IDIM], oSat, oFullCnt
//   slave modport  : used by the buffer
//   master modport : used by whoever drives lanes and consumes windows
interface acc_buffer_ring_if #(
    parameter int IDIM  = 4,
    parameter int IWID  = 1,
    parameter int OWID  = 8,
    parameter int NBANK = 2
) ();
    localparam int CW = $clog2(NBANK + 1);

    logic            iValid;
    logic            oInReady;
    logic            iLast;
    logic            iClear;
    logic [IWID-1:0] iData [IDIM];
    logic            oValid;
    logic            iOutReady;
    logic [OWID-1:0] oData [IDIM];
    logic [IDIM-1:0] oSat;
    logic [CW-1:0]   oFullCnt;

    modport slave (
        input  iValid, iLast, iClear, iData, iOutReady,
        output oInReady, oValid, oData, oSat, oFullCnt
    );

    modport master (
        output iValid, iLast, iClear, iData, iOutReady,
        input  oInReady, oValid, oData, oSat, oFullCnt
    );
endinterface

// File: rtl/acc_buffer_ring_bank.sv
// acc_bank: one bank of the rotating accumulation buffer.
//   clk, rst_n  : clock, asynchronous active-low reset
//   add_en_i    : add data_i into the lanes this edge
//   complete_i  : the added beat closes the window (bank becomes FULL)
//   clear_i     : abort the window (zero contents, back to EMPTY)
//   drain_i     : window consumed (zero contents, back to EMPTY)
//   data_i      : input lanes
//   state_o     : bank state
//   acc_o/sat_o : lane accumulators and sticky overflow flags
// Optional macro ACC_BUF_SAT_EN: clamp at 2^OWID-1 instead of wrapping.
module acc_bank
    import acc_buffer_pkg::*;
#(
    parameter int IDIM = 4,
    parameter int IWID = 1,
    parameter int OWID = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            add_en_i,
    input  logic            complete_i,
    input  logic            clear_i,
    input  logic            drain_i,
    input  logic [IWID-1:0] data_i [IDIM],
    output bank_state_t     state_o,
    output logic [OWID-1:0] acc_o [IDIM],
    output logic [IDIM-1:0] sat_o
);
    bank_state_t     state_q;
    logic [OWID-1:0] acc_q [IDIM];
    logic            sat_q [IDIM];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else if (drain_i || clear_i) begin
            state_q <= EMPTY;
        end else if (add_en_i) begin
            state_q <= complete_i ? FULL : ACC;
        end
    end

    assign state_o = state_q;

    for (genvar gi = 0; gi < IDIM; gi++) begin : g_lane
        logic [OWID:0]   sum_w;
        logic            carry_w;
        logic [OWID-1:0] acc_d;

        always_comb begin
            sum_w   = {1'b0, acc_q[gi]} + (OWID+1)'(data_i[gi]);
            carry_w = sum_w[OWID];
`ifdef ACC_BUF_SAT_EN
            acc_d   = carry_w ? {OWID{1'b1}} : sum_w[OWID-1:0];
`else
            acc_d   = sum_w[OWID-1:0];
`endif
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_q[gi] <= '0;
                sat_q[gi] <= 1'b0;
            end else if (drain_i || clear_i) begin
                acc_q[gi] <= '0;
                sat_q[gi] <= 1'b0;
            end else if (add_en_i) begin
                acc_q[gi] <= acc_d;
                sat_q[gi] <= sat_q[gi] | carry_w;
            end
        end

        assign acc_o[gi] = acc_q[gi];
        assign sat_o[gi] = sat_q[gi];
    end

endmodule

// File: rtl/acc_buffer_ring.sv
// acc_buffer_ring: NBANK-bank rotating accumulation buffer.
// Lanes accumulate into bank[wptr]; completed windows drain from bank[rptr].
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : acc_buffer_ring_if.slave (input beats, output windows,
//                per-lane sticky saturation, count of FULL banks)
// Optional macro ACC_BUF_SAT_EN (in acc_bank): clamp instead of wrap.
module acc_buffer_ring
    import acc_buffer_pkg::*;
#(
    parameter int IDIM  = 4,
    parameter int IWID  = 1,
    parameter int OWID  = 8,
    parameter int NBANK = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    acc_buffer_ring_if.slave   bus
);
    localparam int PW = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int CW = $clog2(NBANK + 1);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] full_cnt_q, full_cnt_d;

    bank_state_t     st_w  [NBANK];
    logic [OWID-1:0] acc_w [NBANK][IDIM];
    logic [IDIM-1:0] sat_w [NBANK];

    logic wr_full_w, rd_valid_w, accept_w, complete_w, clear_w, drain_w;

    // Ready and valid look only at registered bank state, so a drain in
    // this cycle never opens the input side until the next cycle.
    assign wr_full_w  = (st_w[wptr_q] == FULL);
    assign rd_valid_w = (st_w[rptr_q] == FULL);
    assign accept_w   = bus.iValid & ~wr_full_w & ~bus.iClear;
    assign complete_w = accept_w & bus.iLast;
    assign clear_w    = bus.iClear & ~wr_full_w;
    assign drain_w    = rd_valid_w & bus.iOutReady;

    for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
        logic is_w, is_r;
        assign is_w = (wptr_q == PW'(gi));
        assign is_r = (rptr_q == PW'(gi));

        acc_bank #(
            .IDIM(IDIM),
            .IWID(IWID),
            .OWID(OWID)
        ) u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .add_en_i   (accept_w & is_w),
            .complete_i (complete_w & is_w),
            .clear_i    (clear_w & is_w),
            .drain_i    (drain_w & is_r),
            .data_i     (bus.iData),
            .state_o    (st_w[gi]),
            .acc_o      (acc_w[gi]),
            .sat_o      (sat_w[gi])
        );
    end

    always_comb begin
        wptr_d     = complete_w ? PW'(ptr_inc(int'(wptr_q), NBANK)) : wptr_q;
        rptr_d     = drain_w    ? PW'(ptr_inc(int'(rptr_q), NBANK)) : rptr_q;
        full_cnt_d = full_cnt_q;
        if (complete_w && !drain_w) begin
            full_cnt_d = full_cnt_q + CW'(1);
        end else if (drain_w && !complete_w) begin
            full_cnt_d = full_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            full_cnt_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            full_cnt_q <= full_cnt_d;
        end
    end

    assign bus.oInReady = ~wr_full_w;
    assign bus.oValid   = rd_valid_w;
    assign bus.oSat     = rd_valid_w ? sat_w[rptr_q] : '0;
    assign bus.oFullCnt = full_cnt_q;

    for (genvar gi = 0; gi < IDIM; gi++) begin : g_out
        assign bus.oData[gi] = rd_valid_w ? acc_w[rptr_q][gi] : '0;
    end

endmodule

// File: tb/tb_acc_buffer_ring.sv
module tb_acc_buffer_ring;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // a: defaults (NBANK=2), b: NBANK=3, c: OWID=4
    acc_buffer_ring_if #(.IDIM(4), .IWID(1), .OWID(8), .NBANK(2)) a_if ();
    acc_buffer_ring_if #(.IDIM(4), .IWID(1), .OWID(8), .NBANK(3)) b_if ();
    acc_buffer_ring_if #(.IDIM(4), .IWID(1), .OWID(4), .NBANK(2)) c_if ();

    acc_buffer_ring #(.IDIM(4), .IWID(1), .OWID(8), .NBANK(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
    acc_buffer_ring #(.IDIM(4), .IWID(1), .OWID(8), .NBANK(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));
    acc_buffer_ring #(.IDIM(4), .IWID(1), .OWID(4), .NBANK(2)) dut_c (.clk(clk), .rst_n(rst_n), .bus(c_if.slave));

    logic [31:0] a_data, b_data;
    logic [15:0] c_data;
    assign a_data = {a_if.oData[3], a_if.oData[2], a_if.oData[1], a_if.oData[0]};
    assign b_data = {b_if.oData[3], b_if.oData[2], b_if.oData[1], b_if.oData[0]};
    assign c_data = {c_if.oData[3], c_if.oData[2], c_if.oData[1], c_if.oData[0]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [3:0] d);
        for (int k = 0; k < 4; k++) a_if.iData[k] = d[k];
    endtask

    task automatic set_b(input logic [3:0] d);
        for (int k = 0; k < 4; k++) b_if.iData[k] = d[k];
    endtask

    task automatic set_c(input logic [3:0] d);
        for (int k = 0; k < 4; k++) c_if.iData[k] = d[k];
    endtask

    logic [15:0] sat_exp;
    int          hs;
    int          sent;

    initial begin
`ifdef ACC_BUF_SAT_EN
        sat_exp = 16'hFFFF;
`else
        sat_exp = 16'h4444;
`endif
        a_if.iValid = 0; a_if.iLast = 0; a_if.iClear = 0; a_if.iOutReady = 0; set_a(4'h0);
        b_if.iValid = 0; b_if.iLast = 0; b_if.iClear = 0; b_if.iOutReady = 0; set_b(4'h0);
        c_if.iValid = 0; c_if.iLast = 0; c_if.iClear = 0; c_if.iOutReady = 0; set_c(4'h0);

        // Reset state
        #2;
        chk("rst_valid", 32'(a_if.oValid), 32'd0);
        chk("rst_inready", 32'(a_if.oInReady), 32'd1);
        chk("rst_fullcnt", 32'(a_if.oFullCnt), 32'd0);
        chk("rst_data", a_data, 32'h0);
        chk("rst_sat", 32'(a_if.oSat), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        $display("[TB] reset checked");

        // Single window: 3 beats of lanes {1,0,1,1}
        a_if.iOutReady = 1; a_if.iValid = 1; set_a(4'b1101);
        step();
        step();
        a_if.iLast = 1;
        step();
        chk("single_valid", 32'(a_if.oValid), 32'd1);
        chk("single_data", a_data, 32'h03030003);
        chk("single_sat", 32'(a_if.oSat), 32'h0);
        chk("single_fullcnt", 32'(a_if.oFullCnt), 32'd1);
        a_if.iValid = 0; a_if.iLast = 0;
        step();
        chk("single_drained_valid", 32'(a_if.oValid), 32'd0);
        chk("single_drained_fullcnt", 32'(a_if.oFullCnt), 32'd0);
        chk("single_drained_inready", 32'(a_if.oInReady), 32'd1);
        $display("[TB] single window done");

        // Back-pressure: two windows with the consumer stalled
        a_if.iOutReady = 0; a_if.iValid = 1; set_a(4'b0001); a_if.iLast = 0;
        step();
        a_if.iLast = 1;
        step();
        set_a(4'b1110);
        step();
        chk("bp_inready", 32'(a_if.oInReady), 32'd0);
        chk("bp_fullcnt", 32'(a_if.oFullCnt), 32'd2);
        chk("bp_win1_data", a_data, 32'h00000002);
        a_if.iOutReady = 1;
        step();
        chk("bp_inready_after_drain", 32'(a_if.oInReady), 32'd1);
        chk("bp_fullcnt_after_drain", 32'(a_if.oFullCnt), 32'd1);
        chk("bp_win2_data", a_data, 32'h01010100);
        a_if.iValid = 0; a_if.iLast = 0;
        step();
        chk("bp_final_fullcnt", 32'(a_if.oFullCnt), 32'd0);
        chk("bp_final_valid", 32'(a_if.oValid), 32'd0);
        $display("[TB] back-pressure done");

        // Clear on beat 2, then one closing beat
        a_if.iOutReady = 0; a_if.iValid = 1; set_a(4'b1111); a_if.iLast = 0;
        step();
        a_if.iClear = 1;
        step();
        chk("clr_valid", 32'(a_if.oValid), 32'd0);
        a_if.iClear = 0; set_a(4'b1010); a_if.iLast = 1;
        step();
        chk("clr_valid_after", 32'(a_if.oValid), 32'd1);
        chk("clr_data", a_data, 32'h01000100);
        a_if.iValid = 0; a_if.iLast = 0; a_if.iOutReady = 1;
        step();
        chk("clr_fullcnt", 32'(a_if.oFullCnt), 32'd0);
        $display("[TB] clear done");

        // Wrap-around on three banks: seven 1-beat windows
        b_if.iOutReady = 1; set_b(4'b1111); b_if.iLast = 1;
        hs = 0; sent = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (b_if.oValid) begin
                hs++;
                chk("wrap_data", b_data, 32'h01010101);
            end
            if (sent < 7) begin
                b_if.iValid = 1;
                if (b_if.oInReady) sent++;
            end else begin
                b_if.iValid = 0;
            end
            step();
        end
        chk("wrap_handshakes", 32'(hs), 32'd7);
        chk("wrap_fullcnt", 32'(b_if.oFullCnt), 32'd0);
        $display("[TB] wrap-around done, %0d handshakes", hs);

        // Saturation: 20 all-ones beats into 4-bit lanes
        c_if.iOutReady = 0; c_if.iValid = 1; set_c(4'b1111);
        for (int k = 0; k < 20; k++) begin
            c_if.iLast = (k == 19);
            step();
        end
        c_if.iValid = 0; c_if.iLast = 0;
        chk("sat_valid", 32'(c_if.oValid), 32'd1);
        chk("sat_data", 32'(c_data), 32'(sat_exp));
        chk("sat_flags", 32'(c_if.oSat), 32'hF);
        c_if.iOutReady = 1;
        step();
        chk("sat_drained_valid", 32'(c_if.oValid), 32'd0);
        chk("sat_drained_flags", 32'(c_if.oSat), 32'h0);
        $display("[TB] saturation done");

        // Reset mid-window with one bank FULL
        a_if.iOutReady = 0; a_if.iValid = 1; set_a(4'b1111); a_if.iLast = 1;
        step();
        a_if.iLast = 0;
        step();
        a_if.iValid = 0;
        chk("mid_fullcnt", 32'(a_if.oFullCnt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(a_if.oValid), 32'd0);
        chk("mid_rst_inready", 32'(a_if.oInReady), 32'd1);
        chk("mid_rst_fullcnt", 32'(a_if.oFullCnt), 32'd0);
        chk("mid_rst_data", a_data, 32'h0);
        chk("mid_rst_sat", 32'(a_if.oSat), 32'h0);
        step();
        rst_n = 1'b1;
        a_if.iValid = 1; set_a(4'b0100); a_if.iLast = 1;
        step();
        a_if.iValid = 0; a_if.iLast = 0;
        chk("post_rst_data", a_data, 32'h00010000);
        chk("post_rst_fullcnt", 32'(a_if.oFullCnt), 32'd1);
        $display("[TB] reset mid-window done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
